// File: rtl/mips_data_mem_responder_if.sv
// Data-memory bus between the core (master) and the data RAM responder (slave).
interface mips_data_mem_responder_if;

    logic        mem_req;
    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_ready;
    logic        mem_excpt;
    logic        busy;

    // Core side: issues requests, receives responses.
    modport master (
        output mem_req,
        output mem_addr,
        output mem_write_en,
        output mem_data_in,
        input  mem_data_out,
        input  mem_ready,
        input  mem_excpt,
        input  busy
    );

    // Memory side: receives requests, returns responses.
    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_write_en,
        input  mem_data_in,
        output mem_data_out,
        output mem_ready,
        output mem_excpt,
        output busy
    );

endinterface

// File: rtl/mips_data_mem_responder.sv
// Multi-cycle data RAM responder for the core's data-memory port.
// A request is latched on acceptance, waits `latency` edges in total, then
// commits (write merge + readback) and raises mem_ready for one cycle.
module mips_data_mem_responder #(
    parameter logic [31:0] data_start = 32'h1000_0000,
    parameter int unsigned words      = 1024,
    parameter int unsigned addr_bits  = 10,
    parameter int unsigned latency    = 2
) (
    input  logic                      clk,
    input  logic                      rst_b,
    mips_data_mem_responder_if.slave  mem
);

    localparam int unsigned AW    = 30;
    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;
    localparam int unsigned CNT_W = 4;

    // Word address of array entry 0, and the array size in the address width.
    localparam logic [AW-1:0]    BASE_WORD = data_start[31:2];
    localparam logic [AW-1:0]    WORDS_AW  = AW'(words);
    // Counter load value: the commit edge is the one that sees cnt==0.
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(latency - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [AW-1:0]        addr_q;
    logic [LANES-1:0]     mask_q;
    logic [DW-1:0]        wdata_q;
    logic [DW-1:0]        data_out_q;
    logic                 ready_q;
    logic                 excpt_q;
    logic                 busy_q;

    // Storage; deliberately not reset so contents survive rst_b.
    logic [DW-1:0]        mem_q [words];

    logic [AW-1:0]        idx_c;
    logic                 in_range_c;
    logic [DW-1:0]        rd_word_c;
    logic [DW-1:0]        merged_c;
    logic [DW-1:0]        data_d;
    logic                 accept_c;
    logic                 commit_c;

    // Range check: modulo-2^30 subtraction makes addresses below the base huge.
    always_comb begin
        idx_c      = addr_q - BASE_WORD;
        in_range_c = (idx_c < WORDS_AW);
    end

    // Read the addressed word and overlay the masked store lanes.
    always_comb begin
        rd_word_c = mem_q[idx_c[addr_bits-1:0]];
        merged_c  = rd_word_c;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask_q[i]) begin
                merged_c[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
        data_d = in_range_c ? merged_c : '0;
    end

    // Accept in IDLE or RESP; commit on the WAIT edge with an expired counter.
    always_comb begin
        accept_c = mem.mem_req && ((state_q == S_IDLE) || (state_q == S_RESP));
        commit_c = (state_q == S_WAIT) && (cnt_q == '0);
    end

    // Request FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            excpt_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        addr_q  <= mem.mem_addr;
                        mask_q  <= mem.mem_write_en;
                        wdata_q <= mem.mem_data_in;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (commit_c) begin
                        data_out_q <= data_d;
                        excpt_q    <= !in_range_c;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b0;
                    excpt_q <= 1'b0;
                    if (accept_c) begin
                        addr_q  <= mem.mem_addr;
                        mask_q  <= mem.mem_write_en;
                        wdata_q <= mem.mem_data_in;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= S_WAIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    excpt_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Array write on the commit edge; reset drops state_q so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (commit_c && in_range_c && (|mask_q)) begin
            mem_q[idx_c[addr_bits-1:0]] <= merged_c;
        end
    end

    assign mem.mem_data_out = data_out_q;
    assign mem.mem_ready    = ready_q;
    assign mem.mem_excpt    = excpt_q;
    assign mem.busy         = busy_q;

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder at latencies 1, 2 and 4.
// All three instances see the same stimulus; `sel` picks which one is checked.
module tb_mips_data_mem_responder;

    logic        clk;
    logic        rst_b;
    logic        req;
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_data_mem_responder_if bus1 ();
    mips_data_mem_responder_if bus2 ();
    mips_data_mem_responder_if bus4 ();

    assign bus1.mem_req = req;  assign bus1.mem_addr = addr;  assign bus1.mem_write_en = we;  assign bus1.mem_data_in = din;
    assign bus2.mem_req = req;  assign bus2.mem_addr = addr;  assign bus2.mem_write_en = we;  assign bus2.mem_data_in = din;
    assign bus4.mem_req = req;  assign bus4.mem_addr = addr;  assign bus4.mem_write_en = we;  assign bus4.mem_data_in = din;

    mips_data_mem_responder #(.latency(1)) u_dut1 (.clk(clk), .rst_b(rst_b), .mem(bus1.slave));
    mips_data_mem_responder #(.latency(2)) u_dut2 (.clk(clk), .rst_b(rst_b), .mem(bus2.slave));
    mips_data_mem_responder #(.latency(4)) u_dut4 (.clk(clk), .rst_b(rst_b), .mem(bus4.slave));

    int          sel;
    logic [31:0] cur_data;
    logic        cur_ready;
    logic        cur_excpt;
    logic        cur_busy;

    always_comb begin
        cur_data  = bus2.mem_data_out;
        cur_ready = bus2.mem_ready;
        cur_excpt = bus2.mem_excpt;
        cur_busy  = bus2.busy;
        if (sel == 1) begin
            cur_data  = bus1.mem_data_out;
            cur_ready = bus1.mem_ready;
            cur_excpt = bus1.mem_excpt;
            cur_busy  = bus1.busy;
        end else if (sel == 4) begin
            cur_data  = bus4.mem_data_out;
            cur_ready = bus4.mem_ready;
            cur_excpt = bus4.mem_excpt;
            cur_busy  = bus4.busy;
        end
    end

    typedef struct packed {
        logic [31:0] data;
        logic        excpt;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_vec;
    int   n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pops the oldest expected response whenever the selected DUT answers.
    rsp_t mon_r;
    always @(negedge clk) begin
        if (rst_b === 1'b1 && cur_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_ready", 32'(cur_ready), 32'd0);
            end else begin
                mon_r = exp_q.pop_front();
                check_val("rsp_data", cur_data, mon_r.data);
                check_val("rsp_excpt", 32'(cur_excpt), 32'(mon_r.excpt));
            end
        end
    end

    // One request on the selected DUT; must be called at a negedge, returns at one.
    task automatic do_req(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d,
                          input logic [31:0] ed, input logic ee);
        rsp_t r;
        int   edges;
        r.data  = ed;
        r.excpt = ee;
        exp_q.push_back(r);
        req  = 1'b1;
        addr = a;
        we   = m;
        din  = d;
        @(posedge clk);
        #1;
        req  = 1'b0;
        addr = 30'($urandom);
        we   = 4'($urandom);
        din  = $urandom;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (cur_ready === 1'b1) break;
        end
        check_val("latency", 32'(edges), 32'(sel));
        repeat (5) @(negedge clk);
    endtask

    // Continuous mem_req for three loads; checks ready/busy cadence every cycle.
    task automatic hs_test(input int s);
        rsp_t r;
        int   seen;
        logic exp_r;
        sel     = s;
        r.data  = 32'h1357_9BDF;
        r.excpt = 1'b0;
        repeat (3) exp_q.push_back(r);
        req  = 1'b1;
        addr = 30'h0400_0005;
        we   = 4'h0;
        din  = $urandom;
        @(posedge clk);
        seen = 0;
        for (int c = 1; c <= 40 && seen < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_r = ((c % (s + 1)) == s);
            check_val("hs_ready", 32'(cur_ready), 32'(exp_r));
            check_val("hs_busy", 32'(cur_busy), 32'(!exp_r));
            if (cur_ready === 1'b1) begin
                seen++;
                if (seen == 3) req = 1'b0;
            end
        end
        req = 1'b0;
        check_val("hs_count", 32'(seen), 32'd3);
        repeat (12) @(negedge clk);
    endtask

    logic [31:0] model [8];
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] merged;

    initial begin
        n_vec = 0;
        n_err = 0;
        sel   = 2;
        req   = 1'b0;
        addr  = '0;
        we    = '0;
        din   = '0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(cur_ready), 32'd0);
        check_val("rst_excpt", 32'(cur_excpt), 32'd0);
        check_val("rst_busy",  32'(cur_busy),  32'd0);
        check_val("rst_data",  cur_data,       32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // Store then load.
        do_req(30'h0400_0000, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        do_req(30'h0400_0000, 4'h0, $urandom,      32'hDEAD_BEEF, 1'b0);

        // Byte-lane merge.
        do_req(30'h0400_0000, 4'b0101, 32'h1122_3344, 32'hDE22_BE44, 1'b0);
        do_req(30'h0400_0000, 4'h0,    $urandom,      32'hDE22_BE44, 1'b0);

        // Idle hold.
        for (int i = 0; i < 10; i++) begin
            check_val("idle_ready", 32'(cur_ready), 32'd0);
            check_val("idle_data",  cur_data,       32'hDE22_BE44);
            check_val("idle_excpt", 32'(cur_excpt), 32'd0);
            @(negedge clk);
        end

        // Range boundaries.
        do_req(30'h0400_03FF, 4'hF, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 1'b0);
        do_req(30'h0400_03FF, 4'h0, $urandom,      32'h0BAD_C0DE, 1'b0);
        do_req(30'h0400_0400, 4'h0, $urandom,      32'h0,         1'b1);
        do_req(30'h03FF_FFFF, 4'h0, $urandom,      32'h0,         1'b1);
        do_req(30'h0400_0400, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b1);
        do_req(30'h0400_0000, 4'h0, $urandom,      32'hDE22_BE44, 1'b0);
        do_req(30'h0400_03FF, 4'h0, $urandom,      32'h0BAD_C0DE, 1'b0);

        // Random masked stores against a small word model.
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            model[i] = wd;
            do_req(30'h0400_0010 + 30'(i), 4'hF, wd, wd, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            wm = 4'($urandom);
            merged = model[i];
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) merged[8*b +: 8] = wd[8*b +: 8];
            end
            model[i] = merged;
            do_req(30'h0400_0010 + 30'(i), wm, wd, merged, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            do_req(30'h0400_0010 + 30'(i), 4'h0, $urandom, model[i], 1'b0);
        end

        // Back-to-back handshake at each latency.
        do_req(30'h0400_0005, 4'hF, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0);
        hs_test(2);
        hs_test(1);
        hs_test(4);

        // Reset mid-operation aborts the store.
        sel  = 2;
        req  = 1'b1;
        addr = 30'h0400_0005;
        we   = 4'hF;
        din  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req = 1'b0;
        check_val("abort_busy_pre", 32'(cur_busy), 32'd1);
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check_val("abort_ready", 32'(cur_ready), 32'd0);
        check_val("abort_busy",  32'(cur_busy),  32'd0);
        check_val("abort_excpt", 32'(cur_excpt), 32'd0);
        check_val("abort_data",  cur_data,       32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_no_ready", 32'(cur_ready), 32'd0);
        end
        rst_b = 1'b1;
        @(negedge clk);
        do_req(30'h0400_0005, 4'h0, $urandom, 32'h1357_9BDF, 1'b0);

        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
